// File: rtl/branch_pht.sv
// Branch direction predictor: table of saturating counters indexed by fetch PC,
// optionally hashed with global history, plus saturating hit/miss statistics.
module branch_pht #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned INIT   = 1,
  parameter int unsigned GSHARE = 1,
  parameter int unsigned HIST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pred_pc,
  output logic              pred_take,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              upd_pred,
  input  logic              stat_clr,
  output logic [15:0]       stat_branch,
  output logic [15:0]       stat_miss
);

  localparam int unsigned DEPTH  = 1 << IDX_W;
  localparam int unsigned STAT_W = 16;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(INIT);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [CNT_W-1:0]  cnt [DEPTH];
  logic [HIST_W-1:0] ghr;
  logic [IDX_W-1:0]  pc_idx;
  logic [IDX_W-1:0]  hist_idx;
  logic [CNT_W-1:0]  cnt_cur;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              unused_pc;

  // Same-cycle prediction from registered state; no bypass of a concurrent update.
  assign pc_idx    = pred_pc[IDX_W+1:2];
  assign hist_idx  = IDX_W'(ghr);
  assign pred_idx  = (GSHARE != 0) ? (pc_idx ^ hist_idx) : pc_idx;
  assign pred_take = cnt[pred_idx][CNT_W-1];
  assign unused_pc = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

  // Saturating step of the counter being trained.
  always_comb begin
    cnt_cur = cnt[upd_idx];
    cnt_nxt = cnt_cur;
    if (upd_taken) begin
      if (cnt_cur != CNT_MAX) cnt_nxt = cnt_cur + CNT_W'(1);
    end else begin
      if (cnt_cur != '0) cnt_nxt = cnt_cur - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) cnt[i] <= CNT_INIT;
    end else if (upd_valid) begin
      cnt[upd_idx] <= cnt_nxt;
    end
  end

  // Truncating the concatenation drops the oldest bit; also covers HIST_W = 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
    end else if (upd_valid) begin
      ghr <= HIST_W'({ghr, upd_taken});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branch <= '0;
      stat_miss   <= '0;
    end else if (stat_clr) begin
      stat_branch <= '0;
      stat_miss   <= '0;
    end else if (upd_valid) begin
      if (stat_branch != STAT_MAX) stat_branch <= stat_branch + STAT_W'(1);
      if ((upd_pred != upd_taken) && (stat_miss != STAT_MAX))
        stat_miss <= stat_miss + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_pht.sv
// Bench for branch_pht: bimodal and gshare instances share stimulus and are
// compared every cycle against an arithmetic model, plus literal spot checks.
module tb_branch_pht;

  localparam int IDX_W   = 6;
  localparam int CNT_W   = 2;
  localparam int INIT    = 1;
  localparam int HIST_W  = 4;
  localparam int ENTRIES = 64;
  localparam int CMAX    = 3;
  localparam int THRESH  = 2;
  localparam int SMAX    = 65535;

  logic        clk;
  logic        rst;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic        upd_pred;
  logic        stat_clr;

  logic        bim_take, gsh_take;
  logic [5:0]  bim_idx, gsh_idx;
  logic [15:0] bim_br, bim_miss, gsh_br, gsh_miss;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  int mcnt [ENTRIES];
  int mghr, mbr, mmiss;

  branch_pht #(.IDX_W(IDX_W), .CNT_W(CNT_W), .INIT(INIT), .GSHARE(0), .HIST_W(HIST_W)) u_bim (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_take(bim_take), .pred_idx(bim_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .stat_clr(stat_clr), .stat_branch(bim_br), .stat_miss(bim_miss));

  branch_pht #(.IDX_W(IDX_W), .CNT_W(CNT_W), .INIT(INIT), .GSHARE(1), .HIST_W(HIST_W)) u_gsh (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_take(gsh_take), .pred_idx(gsh_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .stat_clr(stat_clr), .stat_branch(gsh_br), .stat_miss(gsh_miss));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) mcnt[i] = INIT;
    mghr = 0;
    mbr = 0;
    mmiss = 0;
  endtask

  // Model: counters as integers, history as a modulo-16 shift, stats as clamped sums.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else begin
      if (stat_clr) begin
        mbr = 0;
        mmiss = 0;
      end else if (upd_valid) begin
        if (mbr < SMAX) mbr = mbr + 1;
        if (upd_pred != upd_taken && mmiss < SMAX) mmiss = mmiss + 1;
      end
      if (upd_valid) begin
        if (upd_taken) mcnt[upd_idx] = (mcnt[upd_idx] < CMAX) ? mcnt[upd_idx] + 1 : CMAX;
        else           mcnt[upd_idx] = (mcnt[upd_idx] > 0) ? mcnt[upd_idx] - 1 : 0;
        mghr = (mghr * 2 + int'(upd_taken)) % (1 << HIST_W);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      int ib, ig;
      ib = int'(pred_pc[31:2]) % ENTRIES;
      ig = ib ^ mghr;
      chk("bim_idx", int'(bim_idx), ib);
      chk("gsh_idx", int'(gsh_idx), ig);
      chk("bim_take", int'(bim_take), int'(mcnt[ib] >= THRESH));
      chk("gsh_take", int'(gsh_take), int'(mcnt[ig] >= THRESH));
      chk("bim_branch", int'(bim_br), mbr);
      chk("bim_miss", int'(bim_miss), mmiss);
      chk("gsh_branch", int'(gsh_br), mbr);
      chk("gsh_miss", int'(gsh_miss), mmiss);
    end
  end

  // Drive one cycle of inputs, return just after the edge that consumed them.
  task automatic cyc(input logic [31:0] pc, input logic v, input int idx,
                     input logic t, input logic p, input logic clr);
    pred_pc   = pc;
    upd_valid = v;
    upd_idx   = 6'(idx);
    upd_taken = t;
    upd_pred  = p;
    stat_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] up_exp;
    logic [3:0] dn_exp;
    rst = 1'b0;
    pred_pc = 32'h0000_0040;
    upd_valid = 1'b0;
    upd_idx = '0;
    upd_taken = 1'b0;
    upd_pred = 1'b0;
    stat_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    started = 1;
    chk("rst_take", int'(bim_take), 0);
    chk("rst_idx", int'(bim_idx), 'h10);
    chk("rst_gidx", int'(gsh_idx), 'h10);
    chk("rst_branch", int'(bim_br), 0);
    chk("rst_miss", int'(bim_miss), 0);
    rst = 1'b1;
    cyc(32'h40, 0, 0, 0, 0, 0);

    // Saturation walk on idx 5: up 1->2->3->3, then down 3->2->1->0->0.
    up_exp = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cyc(32'h14, 1, 5, 1, 1, 0);
      chk("sat_up_take", int'(bim_take), int'(up_exp[i]));
    end
    dn_exp = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      cyc(32'h14, 1, 5, 0, 0, 0);
      chk("sat_dn_take", int'(bim_take), int'(dn_exp[i]));
    end
    cyc(32'h14, 0, 0, 0, 0, 0);

    // Three taken updates after not-taken history give ghr = 4'b0111.
    for (int i = 0; i < 3; i++) cyc(32'h40, 1, 9, 1, 1, 0);
    cyc(32'h40, 0, 0, 0, 0, 0);
    chk("gshare_idx", int'(gsh_idx), 'h17);
    chk("bimodal_idx", int'(bim_idx), 'h10);

    // Predict and train idx 3 in the same cycle: old counter value is seen.
    pred_pc = 32'h0000_000C;
    upd_valid = 1'b1;
    upd_idx = 6'd3;
    upd_taken = 1'b1;
    upd_pred = 1'b0;
    #2;
    chk("hazard_before", int'(bim_take), 0);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    #1;
    chk("hazard_after", int'(bim_take), 1);
    cyc(32'h0C, 0, 0, 0, 0, 0);

    // Statistics: clear, then 5 updates with 2 mispredicts.
    cyc(32'h40, 0, 0, 0, 0, 1);
    chk("clr_branch", int'(bim_br), 0);
    chk("clr_miss", int'(bim_miss), 0);
    cyc(32'h50, 1, 20, 1, 1, 0);
    cyc(32'h50, 1, 20, 1, 0, 0);
    cyc(32'h50, 1, 20, 0, 0, 0);
    chk("stat3_branch", int'(bim_br), 3);
    chk("stat3_miss", int'(bim_miss), 1);
    cyc(32'h50, 1, 20, 0, 1, 0);
    cyc(32'h50, 1, 20, 1, 1, 0);
    chk("stat5_branch", int'(bim_br), 5);
    chk("stat5_miss", int'(bim_miss), 2);
    cyc(32'h50, 1, 20, 1, 0, 1);
    chk("clr_upd_branch", int'(gsh_br), 0);
    chk("clr_upd_miss", int'(gsh_miss), 0);

    // Drive both statistics into saturation with all-mispredicted updates.
    for (int i = 1; i <= 65540; i++) begin
      cyc(32'(i * 4), 1, i % 64, logic'(i % 2), logic'((i + 1) % 2), 0);
      if (i == 65534) chk("near_sat_branch", int'(bim_br), 'hFFFE);
      if (i == 65535) chk("at_sat_branch", int'(bim_br), 'hFFFF);
    end
    chk("sat_branch", int'(bim_br), 'hFFFF);
    chk("sat_miss", int'(bim_miss), 'hFFFF);

    // Async reset in mid-cycle during a stream of taken updates to idx 7.
    for (int i = 0; i < 3; i++) cyc(32'h1C, 1, 7, 1, 1, 0);
    chk("pre_rst_take", int'(bim_take), 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_take", int'(bim_take), 0);
    chk("arst_branch", int'(bim_br), 0);
    chk("arst_miss", int'(gsh_miss), 0);
    @(posedge clk);
    #1;
    pred_pc = 32'h0000_0040;
    #1;
    chk("arst_ghr_idx", int'(gsh_idx), 'h10);
    rst = 1'b1;
    cyc(32'h1C, 0, 0, 0, 0, 0);
    chk("post_rst_take", int'(bim_take), 0);
    cyc(32'h1C, 1, 7, 1, 1, 0);
    chk("post_rst_train", int'(bim_take), 1);
    chk("post_rst_branch", int'(bim_br), 1);
    cyc(32'h1C, 0, 0, 0, 0, 0);

    started = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
